// File: rtl/nibble_mult_accum_if.sv
// ---------------------------------------------------------------------------
// nibble_mult_accum_if
// Groups the operand/handshake signals of nibble_mult_accum.
//   start      : request to begin a multiply
//   nib_a/nib_b: operand nibbles returned by the upstream 4:1 muxes
//   sel_a/sel_b: nibble selects driven to those muxes (0 = low, else high)
//   product    : accumulated 16-bit unsigned product
//   busy       : high while the multiplier is accumulating
//   done_flag  : result valid
// Modports: master = requester/operand-source side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface nibble_mult_accum_if;
  logic        start;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [15:0] product;
  logic        busy;
  logic        done_flag;

  modport master (
    output start, nib_a, nib_b,
    input  sel_a, sel_b, product, busy, done_flag
  );

  modport slave (
    input  start, nib_a, nib_b,
    output sel_a, sel_b, product, busy, done_flag
  );
endinterface

// File: rtl/nibble_mult_accum.sv
// ---------------------------------------------------------------------------
// nibble_mult_accum
// 8x8 unsigned multiplier built from four 4x4 nibble products accumulated
// over four cycles. Operand nibbles are fetched through external 4:1 muxes
// steered by sel_a/sel_b.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high reset (wins over start)
//   bus   : nibble_mult_accum_if.slave (start, nib_a, nib_b in;
//           sel_a, sel_b, product, busy, done_flag out)
//
// Configuration macro:
//   DONE_PULSE_EN - when defined, DONE lasts one cycle (done_flag is a
//                   single-cycle pulse) and start is ignored in DONE.
//                   When undefined, DONE is held until start or reset.
// ---------------------------------------------------------------------------
module nibble_mult_accum (
  input  logic                       clk,
  input  logic                       reset,
  nibble_mult_accum_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  k_r;
  logic [1:0]  k_s;
  logic [15:0] product_r;
  logic [15:0] product_s;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  pp_s;
  logic [15:0] term_s;

  // Nibble partial product aligned to its weight for the current step.
  // Steps 1 and 2 are the two cross terms, both weighted by 2^4.
  always_comb begin
    pp_s   = {4'h0, bus.nib_a} * {4'h0, bus.nib_b};
    term_s = 16'h0000;
    case (k_r)
      2'd0:    term_s = {8'h00, pp_s};
      2'd1:    term_s = {4'h0, pp_s, 4'h0};
      2'd2:    term_s = {4'h0, pp_s, 4'h0};
      2'd3:    term_s = {pp_s, 8'h00};
      default: term_s = 16'h0000;
    endcase
  end

  // Next-state, step counter and accumulator update.
  always_comb begin
    state_s   = state_r;
    k_s       = k_r;
    product_s = product_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s   = CALC;
          k_s       = 2'd0;
          product_s = 16'h0000;
        end else begin
          state_s   = IDLE;
        end
      end
      CALC: begin
        // start is deliberately not looked at here: no restart mid-multiply
        product_s = product_r + term_s;
        k_s       = k_r + 2'd1;
        if (k_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
`ifdef DONE_PULSE_EN
        state_s = IDLE;
`else
        if (bus.start) begin
          state_s   = CALC;
          k_s       = 2'd0;
          product_s = 16'h0000;
        end else begin
          state_s   = DONE;
        end
`endif
      end
      default: begin
        state_s   = IDLE;
        k_s       = 2'd0;
        product_s = 16'h0000;
      end
    endcase
  end

  // State, counter, accumulator and status flag registers.
  // busy/done are registered from the next state so they align with state_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      k_r       <= 2'd0;
      product_r <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      product_r <= product_s;
      busy_r    <= (state_s == CALC);
      done_r    <= (state_s == DONE);
    end
  end

  // Mux selects must follow k within the same cycle, so they stay
  // combinational; outside CALC they park on the low nibble.
  always_comb begin
    if (state_r == CALC) begin
      bus.sel_a = {1'b0, k_r[0]};
      bus.sel_b = {1'b0, k_r[1]};
    end else begin
      bus.sel_a = 2'b00;
      bus.sel_b = 2'b00;
    end
  end

  assign bus.product   = product_r;
  assign bus.busy      = busy_r;
  assign bus.done_flag = done_r;

endmodule

// File: tb/tb_nibble_mult_accum.sv
// ---------------------------------------------------------------------------
// tb_nibble_mult_accum
// Directed-vector bench for nibble_mult_accum. Models the two upstream 4:1
// nibble muxes from the DUT selects and checks cycle-by-cycle behaviour
// against hand-computed products.
// ---------------------------------------------------------------------------
module tb_nibble_mult_accum;

  logic       clk;
  logic       reset;
  logic [7:0] op_a;
  logic [7:0] op_b;
  int         n_checks;
  int         n_errors;

  nibble_mult_accum_if bus ();

  nibble_mult_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Upstream mux model: 0 selects the low nibble, anything else the high one.
  assign bus.nib_a = (bus.sel_a == 2'd0) ? op_a[3:0] : op_a[7:4];
  assign bus.nib_b = (bus.sel_b == 2'd0) ? op_b[3:0] : op_b[7:4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_prod);
    check_val({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, ".done"}, {31'd0, bus.done_flag}, 32'd0);
    check_val({tag, ".sel_a"}, {30'd0, bus.sel_a}, 32'd0);
    check_val({tag, ".sel_b"}, {30'd0, bus.sel_b}, 32'd0);
    check_val({tag, ".product"}, {16'd0, bus.product}, {16'd0, exp_prod});
  endtask

  // One multiply from IDLE/DONE: load edge, four CALC cycles, then DONE.
  task automatic run_mult(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic hold_start,
                          input logic [15:0] exp_prod);
    logic [1:0] kk;
    op_a      = a;
    op_b      = b;
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kk = i[1:0];
      check_val({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
      check_val({tag, ".done_early"}, {31'd0, bus.done_flag}, 32'd0);
      check_val({tag, ".sel_a"}, {30'd0, bus.sel_a}, {31'd0, kk[0]});
      check_val({tag, ".sel_b"}, {30'd0, bus.sel_b}, {31'd0, kk[1]});
      tick();
    end
    check_val({tag, ".done"}, {31'd0, bus.done_flag}, 32'd1);
    check_val({tag, ".busy_end"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, ".sel_a_end"}, {30'd0, bus.sel_a}, 32'd0);
    check_val({tag, ".sel_b_end"}, {30'd0, bus.sel_b}, 32'd0);
    check_val({tag, ".product"}, {16'd0, bus.product}, {16'd0, exp_prod});
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    bus.start = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    check_idle("reset", 16'h0000);
    reset = 1'b0;
    tick();
    check_idle("idle", 16'h0000);

    // Mixed-nibble operands, full cycle-by-cycle check
    run_mult("f0xc3", 8'hF0, 8'hC3, 1'b0, 16'hB6D0);

    // DONE behaviour and product retention
`ifdef DONE_PULSE_EN
    tick();
    check_idle("pulse_drop", 16'hB6D0);
    for (int i = 0; i < 10; i++) tick();
    check_idle("pulse_hold", 16'hB6D0);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("done_hold", {31'd0, bus.done_flag}, 32'd1);
      check_val("prod_hold", {16'd0, bus.product}, 32'h0000B6D0);
    end
`endif

    // All-ones operands, then an immediate restart from DONE
    run_mult("ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
`ifdef DONE_PULSE_EN
    tick();
`endif
    run_mult("12x34", 8'h12, 8'h34, 1'b0, 16'h03A8);

    // Zero operand still completes with normal latency
    run_mult("00xa5", 8'h00, 8'hA5, 1'b0, 16'h0000);

    // start held through CALC must not restart the multiply
    run_mult("hold_start", 8'h5A, 8'h3C, 1'b1, 16'h1518);
`ifdef DONE_PULSE_EN
    tick();
`else
    tick();
    check_val("hold_done_stays", {31'd0, bus.done_flag}, 32'd1);
`endif

    // Reset in the second CALC cycle
    op_a      = 8'hF0;
    op_b      = 8'hC3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_val("mid.busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset", 16'h0000);
    tick();
    check_idle("after_reset", 16'h0000);
    run_mult("0fx0f", 8'h0F, 8'h0F, 1'b0, 16'h00E1);

    // Reset beats start at the same edge
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    check_idle("rst_prio", 16'h0000);
    tick();
    check_idle("rst_prio_next", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_mult_accum.md
NIBBLE_MULT_ACCUM -- requirements
Module: nibble_mult_accum

Interface
REQ-001 Parameters: none; the operand width is fixed at 8 bits and the product width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on the rising edge.
REQ-005 nib_a  input  4  operand A nibble returned by the upstream mux4 A (combinational path from sel_a).
REQ-006 nib_b  input  4  operand B nibble returned by the upstream mux4 B (combinational path from sel_b).
REQ-007 sel_a  output  2  select for mux4 A; 0 = low nibble, nonzero = high nibble.
REQ-008 sel_b  output  2  select for mux4 B; same encoding as sel_a.
REQ-009 product  output  16  accumulated 8x8 unsigned product.
REQ-010 busy  output  1  high while in CALC.
REQ-011 done_flag  output  1  result valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE, plus a 2-bit step counter k.
REQ-013 In IDLE with start=1, at the clock edge: state to CALC, k=0, product=0.
REQ-014 In CALC, sel_a SHALL equal {1'b0,k[0]} and sel_b SHALL equal {1'b0,k[1]}, both combinational from k.
REQ-015 On each CALC edge, product SHALL increase by (nib_a*nib_b) shifted left by 0 (k=0), 4 (k=1), 4 (k=2) or 8 (k=3); the addition is 16-bit unsigned and never overflows.
REQ-016 k SHALL increment on each CALC edge; on the edge where k=3 the state SHALL move to DONE.
REQ-017 Latency: done_flag SHALL be high in the cycle exactly 5 edges after the edge that sampled start (1 load edge + 4 accumulate edges).
REQ-018 start SHALL be ignored while in CALC.
REQ-019 In IDLE and DONE, sel_a and sel_b SHALL be 0.
REQ-020 product SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-021 done_flag SHALL be 1 only in DONE; busy SHALL be 1 only in CALC.
REQ-022 In DONE with start=1 (non-pulse mode), the block SHALL behave as REQ-013: state to CALC, k=0, product=0, done_flag low on the next cycle.
REQ-023 The block SHALL place no requirement on operands changing during CALC; it multiplies whatever nibbles are presented each cycle.

Reset
REQ-024 On reset=1 at an edge, from any state including mid-CALC: state=IDLE, k=0, product=0, done_flag=0, busy=0, sel_a=sel_b=0.
REQ-025 reset SHALL take priority over start at the same edge.

Configuration
REQ-026 Macro DONE_PULSE_EN, when defined: DONE lasts exactly one cycle, done_flag is a single-cycle pulse, the state returns to IDLE on the next edge, and start sampled in DONE is ignored.
REQ-027 Without DONE_PULSE_EN: DONE is held and done_flag stays high until an accepted start or reset.
REQ-028 product retention per REQ-020 SHALL be identical in both configurations.

Verification
REQ-029 Operands 0xF0 x 0xC3, start pulse -> busy high for 4 cycles, sel pairs (a,b) = (0,0),(1,0),(0,1),(1,1), done_flag high 5 edges after start, product=0xB6D0.
REQ-030 Operands 0xFF x 0xFF -> product=0xFE01; operands 0x12 x 0x34 back-to-back restart from DONE -> product=0x03A8.
REQ-031 Operands 0x00 x 0xA5 -> product=0x0000, done_flag asserted with normal latency.
REQ-032 reset asserted at the second CALC cycle -> next cycle state IDLE, product=0, busy=0, done_flag=0; a subsequent 0x0F x 0x0F multiply -> 0x00E1.
REQ-033 start held high throughout CALC -> no restart; product=correct value, done_flag at the nominal cycle.
REQ-034 Build with DONE_PULSE_EN -> done_flag high for exactly 1 cycle, then IDLE, product retained; build without it -> done_flag held high for 10+ cycles until start.
